mb_add_seq: RTL and testbench

MB_ADD_SEQ -- requirements
Module: mb_add_seq

---
 rtl/alu_pkg.sv | 16 +
 rtl/adder.sv | 40 ++++
 rtl/mb_add_seq.sv | 131 +++++++++++++
 tb/tb_mb_add_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and
// function-select codes for the 8-bit adder slice.
package alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] FS_ADD = 3'b000;
    localparam logic [2:0] FS_AND = 3'b001;
    localparam logic [2:0] FS_OR  = 3'b010;
    localparam logic [2:0] FS_XOR = 3'b011;

endpackage

// File: rtl/adder.sv
// 8-bit ripple-carry adder slice with a small function select.
// C/V are meaningful only for FS_ADD; logic ops report 0.
import alu_pkg::*;

module adder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       CI,
    input  logic [2:0] FS,
    output logic [7:0] Y,
    output logic       C,
    output logic       V
);

    // Ripple chain for add; V from carry into vs. out of bit 7
    always_comb begin
        logic [8:0] c;
        c    = '0;
        c[0] = CI;
        Y    = '0;
        C    = 1'b0;
        V    = 1'b0;
        case (FS)
            FS_ADD: begin
                for (int k = 0; k < 8; k++) begin
                    Y[k]   = A[k] ^ B[k] ^ c[k];
                    c[k+1] = (A[k] & B[k])
                           | (c[k] & (A[k] ^ B[k]));
                end
                C = c[8];
                V = c[8] ^ c[7];
            end
            FS_AND:  Y = A & B;
            FS_OR:   Y = A | B;
            FS_XOR:  Y = A ^ B;
            default: Y = A;
        endcase
    end

endmodule

// File: rtl/mb_add_seq.sv
// Multi-byte add/subtract that walks one shared 8-bit adder
// across the operands, LSB byte first, one byte per cycle.
import alu_pkg::*;

module mb_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry,
    output logic                  ovf,
    output logic                  zero
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t          r_state;
    state_t          w_next;
    logic            w_load;
    logic            w_step;
    logic            w_last;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;
    logic [IW-1:0]   r_idx;
    logic            r_cy;
    logic [W-1:0]    r_result;
    logic            r_carry;
    logic            r_ovf;

    logic [7:0]      w_a;
    logic [7:0]      w_b;
    logic [7:0]      w_y;
    logic            w_c;
    logic            w_v;

    assign w_last = (r_idx == LAST);
    assign w_a    = r_a[r_idx*8 +: 8];
    assign w_b    = r_b[r_idx*8 +: 8] ^ {8{r_sub}};

    adder u_adder (
        .A  (w_a),
        .B  (w_b),
        .CI (r_cy),
        .FS (FS_ADD),
        .Y  (w_y),
        .C  (w_c),
        .V  (w_v)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next state and datapath strobes; start is ignored in RUN
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture and per-byte accumulation; index holds at LAST
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_idx    <= '0;
            r_cy     <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_load) begin
            r_a   <= op_a;
            r_b   <= op_b;
            r_sub <= sub;
            r_idx <= '0;
            r_cy  <= sub;
        end else if (w_step) begin
            r_result[r_idx*8 +: 8] <= w_y;
            r_cy                   <= w_c;
            if (w_last) begin
                r_carry <= w_c;
                r_ovf   <= w_v;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign carry  = r_carry;
    assign ovf    = r_ovf;
    assign zero   = (r_result == '0);

endmodule

// File: tb/tb_mb_add_seq.sv
// Directed bench for mb_add_seq (NBYTES=4): arithmetic corner
// cases, latency, busy-ignore, back-to-back and mid-run reset.
module tb_mb_add_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        sub;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry;
    logic        ovf;
    logic        zero;

    int n_cmp = 0;
    int n_err = 0;

    mb_add_seq #(.NBYTES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .sub     (sub),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry),
        .ovf     (ovf),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Stimulus only: start one op from a negedge and return the
    // number of rising edges until done is seen (-1 on timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, output int lat);
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        lat   = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        sub     = 1'b0;
        op_a    = '0;
        op_b    = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done);
        end
        n_cmp++;
        if (result !== 32'h0 || carry !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_data res=%h c=%b v=%b want 0 0 0",
                     result, carry, ovf);
        end
        n_cmp++;
        if (zero !== 1'b1) begin
            n_err++;
            $display("FAIL reset_zero got %b want 1", zero);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_add_carry_chain;
        int lat;
        run_op(32'h0000FFFF, 32'h00000001, 1'b0, lat);
        n_cmp++;
        if (lat !== 5) begin
            n_err++;
            $display("FAIL add_latency got %0d want 5", lat);
        end
        n_cmp++;
        if (result !== 32'h00010000) begin
            n_err++;
            $display("FAIL add_result got %h want 00010000", result);
        end
        n_cmp++;
        if ({carry, ovf, zero} !== 3'b000) begin
            n_err++;
            $display("FAIL add_flags cvz got %b want 000",
                     {carry, ovf, zero});
        end
    endtask

    task automatic test_subtract;
        int lat;
        run_op(32'h00000000, 32'h00000001, 1'b1, lat);
        n_cmp++;
        if (lat !== 5 || result !== 32'hFFFFFFFF) begin
            n_err++;
            $display("FAIL sub_borrow lat=%0d res=%h want 5 ffffffff",
                     lat, result);
        end
        n_cmp++;
        if ({carry, ovf, zero} !== 3'b000) begin
            n_err++;
            $display("FAIL sub_borrow_flags cvz got %b want 000",
                     {carry, ovf, zero});
        end
        run_op(32'h00000005, 32'h00000003, 1'b1, lat);
        n_cmp++;
        if (result !== 32'h2 || {carry, ovf, zero} !== 3'b100) begin
            n_err++;
            $display("FAIL sub_noborrow res=%h cvz=%b want 2 100",
                     result, {carry, ovf, zero});
        end
        run_op(32'h80000000, 32'h00000001, 1'b1, lat);
        n_cmp++;
        if (result !== 32'h7FFFFFFF || {carry, ovf} !== 2'b11) begin
            n_err++;
            $display("FAIL sub_ovf res=%h cv=%b want 7fffffff 11",
                     result, {carry, ovf});
        end
    endtask

    task automatic test_overflow_wrap;
        int lat;
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
        n_cmp++;
        if (result !== 32'h80000000 || {carry, ovf, zero} !== 3'b010) begin
            n_err++;
            $display("FAIL add_ovf res=%h cvz=%b want 80000000 010",
                     result, {carry, ovf, zero});
        end
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
        n_cmp++;
        if (result !== 32'h0 || {carry, ovf, zero} !== 3'b101) begin
            n_err++;
            $display("FAIL add_wrap res=%h cvz=%b want 00000000 101",
                     result, {carry, ovf, zero});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (result !== 32'h0 || {carry, zero, done, busy} !== 4'b1100) begin
            n_err++;
            $display("FAIL idle_hold res=%h czdb=%b want 0 1100",
                     result, {carry, zero, done, busy});
        end
    endtask

    task automatic test_back_to_back;
        int t1;
        int gap;
        op_a  = 32'h00000010;
        op_b  = 32'h00000020;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_busy got %b want 1", busy);
        end
        op_a  = 32'hAAAAAAAA;
        op_b  = 32'h11111111;
        sub   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        op_a  = 32'h12345678;
        op_b  = 32'h11111111;
        sub   = 1'b0;
        start = 1'b1;
        t1 = -1;
        for (int k = 3; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                t1 = k;
                break;
            end
        end
        n_cmp++;
        if (t1 !== 5 || result !== 32'h00000030) begin
            n_err++;
            $display("FAIL busy_ignore t=%0d res=%h want 5 00000030",
                     t1, result);
        end
        gap = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            if (k == 1) #1 start = 1'b0;
            @(negedge clk);
            if (done) begin
                gap = k;
                break;
            end
        end
        n_cmp++;
        if (gap !== 5) begin
            n_err++;
            $display("FAIL b2b_gap got %0d want 5", gap);
        end
        n_cmp++;
        if (result !== 32'h23456789 || {carry, ovf} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_result res=%h cv=%b want 23456789 00",
                     result, {carry, ovf});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int lat;
        logic seen;
        op_a  = 32'h01010101;
        op_b  = 32'h02020202;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_err++;
            $display("FAIL midrun_reset busy=%b done=%b res=%h want 0 0 0",
                     busy, done, result);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_no_done got %b want 0", seen);
        end
        run_op(32'h01010101, 32'h02020202, 1'b0, lat);
        n_cmp++;
        if (lat !== 5 || result !== 32'h03030303) begin
            n_err++;
            $display("FAIL after_reset lat=%0d res=%h want 5 03030303",
                     lat, result);
        end
    endtask

    initial begin
        test_reset;
        test_add_carry_chain;
        test_subtract;
        test_overflow_wrap;
        test_back_to_back;
        test_reset_mid_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
